// File: rtl/cmd_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_frame_rx_pkg
// Description : Shared constants, state encoding and helpers for the command
//               frame receiver and its frame RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_frame_rx_pkg;

    // Largest accepted frame in bytes, checksum included
    localparam int CMD_MAX_FRAME  = 256;
    // Smallest accepted frame in bytes
    localparam int CMD_MIN_FRAME  = 5;
    // Minimum idle cycles after each output burst (must be at least 1)
    localparam int CMD_GAP_CYCLES = 2;
    // Width of the frame statistics counters
    localparam int CMD_CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SEND  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CMD_CNT_W-1:0] sat_inc(input logic [CMD_CNT_W-1:0] value);
        return (value == {CMD_CNT_W{1'b1}}) ? value : value + {{(CMD_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : cmd_frame_ram
// Description : Simple dual-port frame buffer, one write and one read port,
//               registered read data (1-cycle latency), contents not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_ram
    import cmd_frame_rx_pkg::*;
#(
    parameter int DEPTH  = CMD_MAX_FRAME,
    parameter int ADDR_W = $clog2(CMD_MAX_FRAME),
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port, data appears the cycle after the address
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/cmd_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : cmd_frame_rx
// Description : Receives UDP payload bytes, buffers one command frame, checks
//               length and XOR checksum, and forwards accepted frames (minus
//               the checksum byte) to the command parser.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_rx
    import cmd_frame_rx_pkg::*;
#(
    parameter int MAX_FRAME  = CMD_MAX_FRAME,
    parameter int MIN_FRAME  = CMD_MIN_FRAME,
    parameter int GAP_CYCLES = CMD_GAP_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           udp_din,
    input  logic                 udp_din_en,
    output logic [7:0]           con_dout,
    output logic                 con_dout_en,
    output logic [CMD_CNT_W-1:0] frame_ok_cnt,
    output logic [CMD_CNT_W-1:0] frame_err_cnt,
    output logic [CMD_CNT_W-1:0] frame_drop_cnt,
    output logic                 busy
);

    localparam int          ADDR_W      = $clog2(MAX_FRAME);
    localparam logic [15:0] c_max_frame = 16'(MAX_FRAME);
    localparam logic [15:0] c_min_frame = 16'(MIN_FRAME);
    localparam logic [15:0] c_gap_last  = 16'(GAP_CYCLES - 1);

    state_t                 r_state;
    logic [15:0]            r_count;
    logic [7:0]             r_xor;
    logic                   r_ovf;
    logic [15:0]            r_len;
    logic [15:0]            r_rd_ptr;
    logic [15:0]            r_sent;
    logic [15:0]            r_gap;
    logic [7:0]             r_dout;
    logic                   r_dout_en;
    logic                   r_busy;
    logic [CMD_CNT_W-1:0]   r_ok_cnt;
    logic [CMD_CNT_W-1:0]   r_err_cnt;
    logic [CMD_CNT_W-1:0]   r_drop_cnt;
    logic                   r_din_en_d;
    logic                   r_ignore;

    logic                   w_start;
    logic                   w_drop;
    logic                   w_accept_first;
    logic                   w_recv_wr;
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic [7:0]             w_rd_data;
    logic                   w_pass;

    // A datagram begins on the rising edge of the byte-valid run; one that
    // begins while a frame is being checked or sent is dropped as a whole.
    assign w_start        = udp_din_en & ~r_din_en_d;
    assign w_drop         = w_start & ((r_state == ST_CHECK) || (r_state == ST_SEND) || (r_state == ST_GAP));
    assign w_accept_first = (r_state == ST_IDLE) & udp_din_en & ~r_ignore;
    assign w_recv_wr      = (r_state == ST_RECV) & udp_din_en & (r_count < c_max_frame);
    assign w_wr_en        = w_accept_first | w_recv_wr;
    assign w_wr_addr      = w_accept_first ? '0 : r_count[ADDR_W-1:0];
    assign w_rd_addr      = r_rd_ptr[ADDR_W-1:0];

    // The checksum byte is included in the XOR, so a clean frame XORs to zero
    assign w_pass = ~r_ovf && (r_count >= c_min_frame) && (r_len == r_count) && (r_xor == 8'h00);

    cmd_frame_ram #(
        .DEPTH  (MAX_FRAME),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (udp_din),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    // Track the input run so a dropped datagram stays ignored until it ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_din_en_d <= 1'b0;
            r_ignore   <= 1'b0;
        end else begin
            r_din_en_d <= udp_din_en;
            if (!udp_din_en) begin
                r_ignore <= 1'b0;
            end else if (w_drop) begin
                r_ignore <= 1'b1;
            end
        end
    end

    // Frame receive / check / send state machine with registered outputs.
    // The read pointer runs one address ahead of the output so the RAM
    // latency is hidden and the first byte leaves on the CHECK edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_xor      <= '0;
            r_ovf      <= 1'b0;
            r_len      <= '0;
            r_rd_ptr   <= '0;
            r_sent     <= '0;
            r_gap      <= '0;
            r_dout     <= '0;
            r_dout_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_ok_cnt   <= '0;
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
            case (r_state)
                ST_IDLE: begin
                    r_rd_ptr <= '0;
                    if (w_accept_first) begin
                        r_state <= ST_RECV;
                        r_count <= 16'd1;
                        r_xor   <= udp_din;
                        r_ovf   <= 1'b0;
                        r_len   <= '0;
                    end
                end
                ST_RECV: begin
                    if (udp_din_en) begin
                        if (r_count < c_max_frame) begin
                            r_count <= r_count + 16'd1;
                            r_xor   <= r_xor ^ udp_din;
                            if (r_count == 16'd2) begin
                                r_len[15:8] <= udp_din;
                            end
                            if (r_count == 16'd3) begin
                                r_len[7:0] <= udp_din;
                            end
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end else begin
                        r_state  <= ST_CHECK;
                        r_busy   <= 1'b1;
                        r_rd_ptr <= 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_pass) begin
                        r_state   <= ST_SEND;
                        r_ok_cnt  <= sat_inc(r_ok_cnt);
                        r_dout    <= w_rd_data;
                        r_dout_en <= 1'b1;
                        r_sent    <= 16'd1;
                        r_rd_ptr  <= r_rd_ptr + 16'd1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_err_cnt <= sat_inc(r_err_cnt);
                    end
                end
                ST_SEND: begin
                    if (r_sent == r_count - 16'd1) begin
                        r_state   <= ST_GAP;
                        r_dout    <= '0;
                        r_dout_en <= 1'b0;
                        r_gap     <= '0;
                    end else begin
                        r_dout    <= w_rd_data;
                        r_dout_en <= 1'b1;
                        r_sent    <= r_sent + 16'd1;
                        r_rd_ptr  <= r_rd_ptr + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == c_gap_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_dout    <= '0;
                    r_dout_en <= 1'b0;
                end
            endcase
        end
    end

    assign con_dout       = r_dout;
    assign con_dout_en    = r_dout_en;
    assign busy           = r_busy;
    assign frame_ok_cnt   = r_ok_cnt;
    assign frame_err_cnt  = r_err_cnt;
    assign frame_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_frame_rx
// Description : Directed scoreboard bench for cmd_frame_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_rx;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  udp_din = 8'h00;
    logic        udp_din_en = 1'b0;
    logic [7:0]  con_dout;
    logic        con_dout_en;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;
    logic [15:0] frame_drop_cnt;
    logic        busy;

    cmd_frame_rx dut (
        .clk            (clk),
        .rst            (rst),
        .udp_din        (udp_din),
        .udp_din_en     (udp_din_en),
        .con_dout       (con_dout),
        .con_dout_en    (con_dout_en),
        .frame_ok_cnt   (frame_ok_cnt),
        .frame_err_cnt  (frame_err_cnt),
        .frame_drop_cnt (frame_drop_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_start_q[$];
    int         exp_ok = 0;
    int         exp_err = 0;
    int         exp_drop = 0;
    int         last_cyc = 0;
    bit         prev_en = 1'b0;
    int         fall_cyc = -100;

    // Monitor: pops expected bytes and burst start cycles, checks idle output and GAP busy
    always @(negedge clk) begin
        int         e_cyc;
        logic [7:0] e_byte;
        if (!rst) begin
            prev_en  = 1'b0;
            fall_cyc = -100;
        end else begin
            if (con_dout_en) begin
                if (!prev_en) begin
                    checks++;
                    if (exp_start_q.size() == 0) begin
                        errors++;
                        $display("FAIL burst_start: unexpected burst at cycle %0d", cyc);
                    end else begin
                        e_cyc = exp_start_q.pop_front();
                        if (cyc != e_cyc) begin
                            errors++;
                            $display("FAIL burst_latency: first byte at cycle %0d, required %0d", cyc, e_cyc);
                        end
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_byte: unexpected byte %02h at cycle %0d", con_dout, cyc);
                end else begin
                    e_byte = exp_q.pop_front();
                    if (con_dout !== e_byte) begin
                        errors++;
                        $display("FAIL out_byte: got %02h, required %02h at cycle %0d", con_dout, e_byte, cyc);
                    end
                end
            end else begin
                checks++;
                if (con_dout !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_dout: got %02h, required 00 at cycle %0d", con_dout, cyc);
                end
                if (prev_en) fall_cyc = cyc;
                if (cyc == fall_cyc || cyc == fall_cyc + 1) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_busy: got %b, required 1 at cycle %0d", busy, cyc);
                    end
                end else if (cyc == fall_cyc + 2) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_end: busy got %b, required 0 at cycle %0d", busy, cyc);
                    end
                end
            end
            prev_en = con_dout_en;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bq_t b);
        foreach (b[i]) begin
            step();
            udp_din_en = 1'b1;
            udp_din    = b[i];
        end
        last_cyc = cyc;
        step();
        udp_din_en = 1'b0;
        udp_din    = 8'h00;
    endtask

    task automatic send_good(input bq_t b);
        drive(b);
        for (int i = 0; i < b.size() - 1; i++) exp_q.push_back(b[i]);
        exp_start_q.push_back(last_cyc + 3);
        exp_ok++;
    endtask

    task automatic send_bad(input bq_t b);
        drive(b);
        exp_err++;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 2000 && !done; i++) begin
            if (exp_q.size() == 0 && exp_start_q.size() == 0 && !busy && !con_dout_en) done = 1'b1;
            else step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: queue %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_ok_cnt"}, int'(frame_ok_cnt), exp_ok);
        check_val({tag, "_err_cnt"}, int'(frame_err_cnt), exp_err);
        check_val({tag, "_drop_cnt"}, int'(frame_drop_cnt), exp_drop);
    endtask

    function automatic logic [7:0] xor_all(input bq_t b);
        logic [7:0] x;
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        return x;
    endfunction

    initial begin
        bq_t good;
        bq_t f;
        bq_t big;
        good = '{8'h04, 8'h01, 8'h00, 8'h06, 8'hAA, 8'hA9};
        big  = '{8'h10, 8'h01, 8'h00, 8'h0C, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        big.push_back(xor_all(big));

        // Reset state
        repeat (3) step();
        check_val("rst_dout_en", int'(con_dout_en), 0);
        check_val("rst_dout", int'(con_dout), 0);
        check_val("rst_busy", int'(busy), 0);
        check_counts("rst");
        rst = 1'b1;
        repeat (2) step();

        // Good frame
        send_good(good);
        wait_idle();
        check_counts("good");

        // Bad checksum, then recovery
        send_bad('{8'h04, 8'h01, 8'h00, 8'h06, 8'hAA, 8'hA8});
        wait_idle();
        check_counts("bad_xor");
        send_good(good);
        wait_idle();
        check_counts("after_bad");

        // Length field mismatch with a correct checksum
        send_bad('{8'h40, 8'h02, 8'h00, 8'h07, 8'h11, 8'h54});
        wait_idle();
        check_counts("len_mismatch");

        // Below minimum length, then exactly minimum length
        send_bad('{8'h01, 8'h02, 8'h00, 8'h03});
        wait_idle();
        check_counts("too_short");
        send_good('{8'h04, 8'h01, 8'h00, 8'h05, 8'h00});
        wait_idle();
        check_counts("min_frame");

        // Overflow burst
        f = {};
        for (int i = 0; i < 300; i++) f.push_back(8'(i));
        send_bad(f);
        wait_idle();
        check_counts("overflow");

        // Exactly maximum length
        f = '{8'h07, 8'h01, 8'h01, 8'h00};
        for (int i = 4; i < 255; i++) f.push_back(8'(i * 3));
        f.push_back(xor_all(f));
        send_good(f);
        wait_idle();
        check_counts("max_frame");

        // Busy drop: second datagram starts one cycle after SEND begins and outlives GAP
        send_good(good);
        repeat (2) step();
        drive(big);
        exp_drop++;
        wait_idle();
        check_counts("busy_drop");

        // Datagram starting on the GAP->IDLE cycle is dropped
        send_good(good);
        repeat (7) step();
        drive(big);
        exp_drop++;
        wait_idle();
        check_counts("gap_edge_drop");

        // Datagram starting on the first IDLE cycle is accepted
        send_good(good);
        repeat (8) step();
        send_good(big);
        wait_idle();
        check_counts("first_idle_accept");

        // Reset on the third output byte
        drive(good);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h01);
        exp_start_q.push_back(last_cyc + 3);
        repeat (4) step();
        rst = 1'b0;
        #1;
        check_val("rst_mid_send_en", int'(con_dout_en), 0);
        check_val("rst_mid_send_busy", int'(busy), 0);
        exp_ok   = 0;
        exp_err  = 0;
        exp_drop = 0;
        repeat (2) step();
        rst = 1'b1;
        check_counts("rst_mid_send");
        repeat (2) step();
        send_good(good);
        wait_idle();
        check_counts("after_rst");

        check_val("leftover_bytes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
